// File: rtl/axi_io_pmp_pkg.sv
// Shared types and constants for the IO-PMP AXI error slave.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// The default channel/request/response structs are a 32-bit data, 8-bit id
// AXI4 slice. Integrations with other widths pass their own struct types
// through the type parameters of axi_io_pmp_err_slv.
package axi_io_pmp_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam logic [1:0]  RESP_SLVERR       = 2'b10;
    localparam logic [1:0]  RESP_DECERR       = 2'b11;
    localparam logic [31:0] ERR_RDATA_PATTERN = 32'hBADC_AB1E;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ID_WIDTH   = 8;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic [31:0]             addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    user;
    } ax_chan_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]   data;
        logic [DEF_DATA_WIDTH/8-1:0] strb;
        logic                        last;
        logic                        user;
    } w_chan_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
        logic                    user;
    } b_chan_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic                      user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// File: rtl/axi_io_pmp_err_r_chan.sv
// Read side of the IO-PMP error slave: accepts one AR, returns len+1 error R beats.
// Latency: AR handshake at cycle N, first R valid at N+1, one beat per cycle after.
// Backpressure: R fields held stable while r_valid && !r_ready; ar_ready low until last R handshake.
//
// Ports: clk_i/rst_ni (async active-low), ar/ar_valid/ar_ready (address in),
//        r/r_valid/r_ready (error data out).
// Build option: IOPMP_ERR_RDATA_EN fills r.data with a repeated 32'hBADC_AB1E
// marker instead of zeros; nothing else changes.
module axi_io_pmp_err_r_chan
    import axi_io_pmp_pkg::*;
#(
    parameter type         ar_chan_t  = axi_io_pmp_pkg::ax_chan_t,
    parameter type         r_chan_t   = axi_io_pmp_pkg::r_chan_t,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter logic [1:0]  ERR_RESP   = RESP_SLVERR
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  ar_chan_t ar,
    input  logic     ar_valid,
    input  logic     r_ready,
    output logic     ar_ready,
    output r_chan_t  r,
    output logic     r_valid
);

`ifdef IOPMP_ERR_RDATA_EN
    // Enough copies of the marker to cover DATA_WIDTH, then cut to size.
    localparam int unsigned             REPS      = (DATA_WIDTH + 31) / 32;
    localparam logic [REPS*32-1:0]      RDATA_REP = {REPS{ERR_RDATA_PATTERN}};
    localparam logic [DATA_WIDTH-1:0]   ERR_RDATA = RDATA_REP[DATA_WIDTH-1:0];
`else
    localparam logic [DATA_WIDTH-1:0]   ERR_RDATA = '0;
`endif

    rd_state_e           state_q;
    logic                live_q;   // keeps ar_ready low while in reset
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic                last_beat;

    // Equality compare on 8 bits: len=255 gives 256 beats without wrapping.
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
            live_q  <= 1'b0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                R_IDLE: begin
                    if (ar_ready && ar_valid) begin
                        id_q    <= ar.id;
                        len_q   <= ar.len;
                        cnt_q   <= '0;
                        state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready) begin
                        if (last_beat) begin
                            state_q <= R_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; fields are zero outside a burst.
    always_comb begin
        ar_ready = live_q && (state_q == R_IDLE);
        r_valid  = (state_q == R_DATA);
        r        = '0;
        if (r_valid) begin
            r.id   = id_q;
            r.data = ERR_RDATA;
            r.resp = ERR_RESP;
            r.last = last_beat;
        end
    end

    // Address, size, burst and user of AR carry no meaning for an error reply.
    logic unused_ar;
    assign unused_ar = ^ar;

endmodule

// File: rtl/axi_io_pmp_err_slv.sv
// Terminating AXI4 error slave for IO-PMP-denied traffic: drains writes, answers every access with ERR_RESP.
// Latency: B valid the cycle after the last-W handshake; first R valid the cycle after the AR handshake.
// Backpressure: one write and one read outstanding; aw/ar_ready stay low until the B / last-R handshake; B and R held until ready.
//
// Ports: clk_i (rising edge), rst_ni (async active-low), axi_req_i (request
//        from the connector / PMP mux), axi_resp_o (response upstream).
// Build option: IOPMP_ERR_RDATA_EN puts a 32'hBADC_AB1E marker on r.data
// (read channel only); undefined gives r.data = 0.
module axi_io_pmp_err_slv
    import axi_io_pmp_pkg::*;
#(
    parameter type         axi_req_t  = axi_io_pmp_pkg::axi_req_t,
    parameter type         axi_rsp_t  = axi_io_pmp_pkg::axi_rsp_t,
    parameter type         ar_chan_t  = axi_io_pmp_pkg::ax_chan_t,
    parameter type         r_chan_t   = axi_io_pmp_pkg::r_chan_t,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter logic [1:0]  ERR_RESP   = RESP_SLVERR
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_resp_o
);

    // ---------------- write FSM ----------------
    wr_state_e           w_state_q;
    logic                w_live_q;   // keeps aw_ready low while in reset
    logic [ID_WIDTH-1:0] b_id_q;
    logic                aw_ready;
    logic                w_ready;
    logic                b_valid;

    assign aw_ready = w_live_q && (w_state_q == W_IDLE);
    // W is refused until AW is in; early W simply waits upstream.
    assign w_ready  = (w_state_q == W_DRAIN);
    assign b_valid  = (w_state_q == W_RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_live_q  <= 1'b0;
            b_id_q    <= '0;
        end else begin
            w_live_q <= 1'b1;
            case (w_state_q)
                W_IDLE: begin
                    if (aw_ready && axi_req_i.aw_valid) begin
                        b_id_q    <= axi_req_i.aw.id;
                        w_state_q <= W_DRAIN;
                    end
                end
                W_DRAIN: begin
                    // aw.len is not tracked: w.last alone ends the burst.
                    if (axi_req_i.w_valid && axi_req_i.w.last) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    logic    ar_ready;
    logic    r_valid;
    r_chan_t r_chan;

    axi_io_pmp_err_r_chan #(
        .ar_chan_t  (ar_chan_t),
        .r_chan_t   (r_chan_t),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .ERR_RESP   (ERR_RESP)
    ) u_r_chan (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .ar       (axi_req_i.ar),
        .ar_valid (axi_req_i.ar_valid),
        .r_ready  (axi_req_i.r_ready),
        .ar_ready (ar_ready),
        .r        (r_chan),
        .r_valid  (r_valid)
    );

    // ---------------- response assembly ----------------
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = b_valid;
        if (b_valid) begin
            axi_resp_o.b.id   = b_id_q;
            axi_resp_o.b.resp = ERR_RESP;
        end
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.r_valid  = r_valid;
        axi_resp_o.r        = r_chan;
    end

    // Write address/data payload is discarded by design.
    logic unused_req;
    assign unused_req = ^{axi_req_i.aw, axi_req_i.w};

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Self-checking bench for axi_io_pmp_err_slv with a 64-bit data struct set.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_axi_io_pmp_err_slv;
    import axi_io_pmp_pkg::*;

    localparam int DW = 64;
    localparam int IW = 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic          user;
    } tb_ax_t;
    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
        logic            user;
    } tb_w_t;
    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          user;
    } tb_b_t;
    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic          user;
    } tb_r_t;
    typedef struct packed {
        tb_ax_t aw;
        logic   aw_valid;
        tb_w_t  w;
        logic   w_valid;
        logic   b_ready;
        tb_ax_t ar;
        logic   ar_valid;
        logic   r_ready;
    } tb_req_t;
    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        tb_b_t  b;
        logic   r_valid;
        tb_r_t  r;
    } tb_rsp_t;

`ifdef IOPMP_ERR_RDATA_EN
    localparam logic [DW-1:0] EXP_RDATA = 64'hBADCAB1E_BADCAB1E;
`else
    localparam logic [DW-1:0] EXP_RDATA = '0;
`endif
    localparam logic [1:0] EXP_RESP = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tb_ax_t  aw_d, ar_d;
    tb_w_t   w_d;
    logic    aw_vld, ar_vld, w_vld, b_rdy, r_rdy;
    tb_req_t req;
    tb_rsp_t rsp;

    always_comb begin
        req          = '0;
        req.aw       = aw_d;
        req.aw_valid = aw_vld;
        req.w        = w_d;
        req.w_valid  = w_vld;
        req.b_ready  = b_rdy;
        req.ar       = ar_d;
        req.ar_valid = ar_vld;
        req.r_ready  = r_rdy;
    end

    axi_io_pmp_err_slv #(
        .axi_req_t  (tb_req_t),
        .axi_rsp_t  (tb_rsp_t),
        .ar_chan_t  (tb_ax_t),
        .r_chan_t   (tb_r_t),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .ERR_RESP   (2'b10)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .axi_req_i  (req),
        .axi_resp_o (rsp)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic          last;
    } r_exp_t;

    r_exp_t        r_q[$];
    logic [IW-1:0] b_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int r_beats = 0;
    int w_beats = 0;
    int ar_hs_cyc = 0;
    int lastw_cyc = 0;
    int hs_aw, hs_ar;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic   r_vld_prev = 1'b0, r_stall_prev = 1'b0, b_vld_prev = 1'b0;
    tb_r_t  r_prev;
    r_exp_t r_e;
    logic [IW-1:0] b_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req.ar_valid && rsp.ar_ready) ar_hs_cyc = cyc;
            if (rsp.r_valid && !r_vld_prev) check("r_first_lat", cyc, ar_hs_cyc + 1);
            if (r_stall_prev) check("r_stable", {63'd0, rsp.r_valid && (rsp.r == r_prev)}, 64'd1);
            if (rsp.r_valid && req.r_ready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    r_e = r_q.pop_front();
                    check("r_id",   rsp.r.id,   r_e.id);
                    check("r_resp", rsp.r.resp, EXP_RESP);
                    check("r_last", rsp.r.last, r_e.last);
                    check("r_data", rsp.r.data, EXP_RDATA);
                    r_beats++;
                end
            end
            r_vld_prev   = rsp.r_valid;
            r_stall_prev = rsp.r_valid && !req.r_ready;
            r_prev       = rsp.r;

            if (req.w_valid && rsp.w_ready) begin
                w_beats++;
                if (req.w.last) lastw_cyc = cyc;
            end
            if (rsp.b_valid && !b_vld_prev) check("b_lat", cyc, lastw_cyc + 1);
            if (rsp.b_valid && req.b_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    b_e = b_q.pop_front();
                    check("b_id",   rsp.b.id,   b_e);
                    check("b_resp", rsp.b.resp, EXP_RESP);
                end
            end
            b_vld_prev = rsp.b_valid;
        end else begin
            r_vld_prev   = 1'b0;
            r_stall_prev = 1'b0;
            b_vld_prev   = 1'b0;
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic do_aw(input logic [IW-1:0] id, input logic [7:0] len, output int hs);
        aw_d     = '0;
        aw_d.id  = id;
        aw_d.len = len;
        aw_vld   = 1'b1;
        hs       = -1;
        for (int k = 0; k < 64 && hs < 0; k++) begin
            @(negedge clk);
            if (rsp.aw_ready) hs = cyc;
        end
        check("aw_accepted", {63'd0, hs >= 0}, 64'd1);
        @(posedge clk); #1;
        aw_vld = 1'b0;
    endtask

    task automatic do_ar(input logic [IW-1:0] id, input logic [7:0] len, output int hs);
        ar_d     = '0;
        ar_d.id  = id;
        ar_d.len = len;
        ar_vld   = 1'b1;
        hs       = -1;
        for (int k = 0; k < 64 && hs < 0; k++) begin
            @(negedge clk);
            if (rsp.ar_ready) hs = cyc;
        end
        check("ar_accepted", {63'd0, hs >= 0}, 64'd1);
        @(posedge clk); #1;
        ar_vld = 1'b0;
    endtask

    task automatic push_r(input logic [IW-1:0] id, input int len);
        r_exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.id   = id;
            e.last = (i == len);
            r_q.push_back(e);
        end
    endtask

    task automatic do_w(input int n);
        logic got;
        for (int i = 0; i < n; i++) begin
            w_d.data = {$urandom, $urandom};
            w_d.strb = '1;
            w_d.last = (i == n - 1);
            w_vld    = 1'b1;
            got      = 1'b0;
            for (int k = 0; k < 64 && !got; k++) begin
                @(negedge clk);
                if (rsp.w_ready) got = 1'b1;
            end
            check("w_accepted", {63'd0, got}, 64'd1);
            @(posedge clk); #1;
        end
        w_vld    = 1'b0;
        w_d.last = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #1;
            if (r_q.size() == 0 && b_q.size() == 0) done = 1'b1;
        end
        check("drain", {63'd0, done}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, b0, n;
        aw_d = '0; ar_d = '0; w_d = '0;
        aw_vld = 1'b0; ar_vld = 1'b0; w_vld = 1'b0;
        b_rdy = 1'b0; r_rdy = 1'b0;
        rst_n = 1'b0;

        // Reset state
        #12;
        check("rst_aw_ready", rsp.aw_ready, 0);
        check("rst_ar_ready", rsp.ar_ready, 0);
        check("rst_w_ready",  rsp.w_ready,  0);
        check("rst_b_valid",  rsp.b_valid,  0);
        check("rst_r_valid",  rsp.r_valid,  0);
        check("rst_b_fields", rsp.b, 0);
        check("rst_r_data",   rsp.r.data, 0);
        check("rst_r_other",  {rsp.r.id, rsp.r.resp, rsp.r.last, rsp.r.user}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: write burst of 4 beats
        b_rdy = 1'b1;
        r_rdy = 1'b1;
        w0 = w_beats;
        b_q.push_back(8'h05);
        do_aw(8'h05, 8'd3, hs_aw);
        do_w(4);
        wait_drain(50);
        check("t1_w_beats", w_beats - w0, 4);

        // 2: read len=7, back-to-back beats
        @(posedge clk); #1;
        push_r(8'h2A, 7);
        do_ar(8'h2A, 8'd7, hs_ar);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_r_consec", rsp.r_valid, 1);
        end
        @(negedge clk);
        check("t2_r_done",        rsp.r_valid,  0);
        check("t2_ar_ready_again", rsp.ar_ready, 1);
        wait_drain(20);

        // 3: len=255 with r_ready toggling every cycle
        @(posedge clk); #1;
        r_rdy = 1'b0;
        push_r(8'h33, 255);
        b0 = r_beats;
        do_ar(8'h33, 8'd255, hs_ar);
        for (int k = 0; k < 2000 && (r_beats - b0) < 256; k++) begin
            @(posedge clk); #1;
            r_rdy = ~r_rdy;
        end
        r_rdy = 1'b1;
        wait_drain(20);
        check("t3_beats", r_beats - b0, 256);

        // 4: AW and AR together, single W beat, B held off 5 cycles
        @(posedge clk); #1;
        b_rdy = 1'b0;
        r_rdy = 1'b1;
        b_q.push_back(8'h11);
        push_r(8'h22, 2);
        fork
            do_aw(8'h11, 8'd0, hs_aw);
            do_ar(8'h22, 8'd2, hs_ar);
        join
        check("t4_same_cycle", hs_aw, hs_ar);
        do_w(1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp.b_valid) n++;
        end
        check("t4_b_held",   n, 5);
        check("t4_r_indep",  r_q.size(), 0);
        @(posedge clk); #1;
        b_rdy = 1'b1;
        wait_drain(20);

        // 5: reset in the middle of a len=7 read
        @(posedge clk); #1;
        r_rdy = 1'b1;
        push_r(8'h44, 7);
        b0 = r_beats;
        do_ar(8'h44, 8'd7, hs_ar);
        for (int k = 0; k < 50 && (r_beats - b0) < 3; k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_r_valid",  rsp.r_valid,  0);
        check("t5_rst_b_valid",  rsp.b_valid,  0);
        check("t5_rst_ar_ready", rsp.ar_ready, 0);
        check("t5_rst_aw_ready", rsp.aw_ready, 0);
        r_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_aw_ready", rsp.aw_ready, 1);
        check("t5_ar_ready", rsp.ar_ready, 1);
        check("t5_no_r",     rsp.r_valid,  0);
        check("t5_no_b",     rsp.b_valid,  0);
        repeat (5) @(negedge clk);

        // 6: single-beat read, data pattern checked by the scoreboard
        @(posedge clk); #1;
        push_r(8'h66, 0);
        b0 = r_beats;
        do_ar(8'h66, 8'd0, hs_ar);
        wait_drain(20);
        check("t6_beats", r_beats - b0, 1);

        check("end_queues_empty", r_q.size() + b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #200000;
        check("timeout", 64'd1, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
